// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a 2-entry instruction buffer.
// Issues word-aligned requests to instruction memory while request credit is
// available, buffers returned words with their fetch address, and handles
// redirects by flushing the buffer and dropping responses still in flight.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined     -> misaligned redirect targets raise fetch_misaligned and park
//                  the unit in HALT until an aligned redirect arrives.
//   not defined -> redirect_pc[1:0] is ignored (treated as zero).
//
// state | meaning
// RUN   | normal fetch; responses go into the buffer
// DRAIN | dropping responses that belong to pre-redirect requests
// HALT  | misaligned redirect seen; no requests, all responses dropped
//         (HALT exists only with FETCH_MISALIGN_CHECK_EN)

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  // Requests in flight plus buffered words never exceed the buffer depth,
  // so every non-discarded response always has a free slot.
  localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
`else
  typedef enum logic [1:0] {RUN, DRAIN} state_t;
`endif

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  discard;
  logic [1:0]  fifo_count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_data [2];

  logic        can_issue;
  logic        req_fire;
  logic        resp_drop;
  logic        push;
  logic        pop;
  logic [1:0]  out_next;
  logic [1:0]  live;
  logic [31:0] resp_pc;
  logic [31:0] redir_tgt;
  logic        redir_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt        = redirect_pc;
  assign redir_misaligned = |redirect_pc[1:0];
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_tgt           = {redirect_pc[31:2], 2'b00};
  assign redir_misaligned    = 1'b0;
`endif

  assign imem_addr   = fetch_pc;
  assign instr_valid = (fifo_count != 2'd0);
  assign instruction = fifo_data[rd_ptr];
  assign pc          = fifo_pc[rd_ptr];

  // Request credit, handshakes, and the fetch address of the returning word.
  // Non-discarded requests are contiguous and end just below fetch_pc, so the
  // oldest live one sits at fetch_pc - 4 * (outstanding - discard).
  always_comb begin
    can_issue = (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state == HALT) can_issue = 1'b0;
`endif
    imem_req_valid = can_issue && !redirect_valid && reset_n;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_drop      = (discard != 2'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state == HALT) resp_drop = 1'b1;
`endif
    push    = imem_resp_valid && !resp_drop;
    pop     = instr_valid && instr_ready;
    live    = outstanding - discard;
    resp_pc = fetch_pc - {28'd0, live, 2'b00};
    case ({req_fire, imem_resp_valid})
      2'b10:   out_next = outstanding + 2'd1;
      2'b01:   out_next = outstanding - 2'd1;
      default: out_next = outstanding;
    endcase
  end

  // Fetch state machine, credit counters and instruction buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      fifo_count  <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= 32'd0;
        fifo_data[i] <= 32'd0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_misaligned <= 1'b0;
`endif
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Redirect wins over push and pop; whatever is in flight is stale.
        fifo_count <= 2'd0;
        rd_ptr     <= 1'b0;
        wr_ptr     <= 1'b0;
        discard    <= out_next;
        if (redir_misaligned) begin
          fetch_pc <= {redir_tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
          fetch_misaligned <= 1'b1;
          state            <= HALT;
`endif
        end else begin
          fetch_pc <= redir_tgt;
          state    <= (out_next != 2'd0) ? DRAIN : RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
          fetch_misaligned <= 1'b0;
`endif
        end
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_resp_valid && (discard != 2'd0)) begin
          discard <= discard - 2'd1;
          if ((state == DRAIN) && (discard == 2'd1)) state <= RUN;
        end
        if (push) begin
          fifo_pc[wr_ptr]   <= resp_pc;
          fifo_data[wr_ptr] <= imem_resp_data;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_count <= fifo_count + 2'(push) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle in-order memory model that can be
// held off to build up outstanding requests, and a decoder that records every
// consumed {pc, instruction} for in-order stream comparison.

module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem_q [$];
  logic [63:0] got [$];
  logic        mem_hold;
  logic [31:0] exp_pc;
  logic        found;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then drive the memory response.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic        popped;
    logic [63:0] head;
    @(negedge clock);
    hs     = imem_req_valid && imem_req_ready;
    a      = imem_addr;
    popped = instr_valid && instr_ready && !redirect_valid;
    head   = {pc, instruction};
    @(posedge clock);
    #1;
    if (popped) got.push_back(head);
    if (hs) mem_q.push_back(a);
    if (!mem_hold && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_q.pop_front() ^ KEY;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
    end
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1;
    check("redir_instr_valid", 32'(instr_valid), 32'd0);
  endtask

  task automatic check_stream(input int min_len);
    logic [63:0] e;
    check("stream_len", 32'(got.size() >= min_len), 32'd1);
    while (got.size() > 0) begin
      e = got.pop_front();
      check("stream_pc", e[63:32], exp_pc);
      check("stream_data", e[31:0], exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic find_pop_with_resp();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (instr_valid && imem_resp_valid) found = 1'b1;
    end
    check("find_pop_resp", 32'(found), 32'd1);
  endtask

  initial begin
    reset_n         = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    mem_hold        = 1'b0;
    exp_pc          = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);

    // Streaming start-up latency and in-order delivery.
    reset_n = 1'b1;
    #1;
    check("c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("c1_imem_addr", imem_addr, 32'd0);
    check("c1_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c2_instr_valid", 32'(instr_valid), 32'd0);
    check("c2_imem_addr", imem_addr, 32'd4);
    tick();
    check("c3_instr_valid", 32'(instr_valid), 32'd1);
    check("c3_pc", pc, 32'd0);
    check("c3_instruction", instruction, KEY);
    repeat (12) tick();
    check_stream(5);

    // Decoder stall: buffer fills to two, requests stop, nothing lost.
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_instr_valid", 32'(instr_valid), 32'd1);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_in_flight", 32'(mem_q.size()), 32'd0);
    check("stall_head_pc", pc, exp_pc);
    instr_ready = 1'b1;
    repeat (10) tick();
    check_stream(4);

    // Redirect with two requests in flight: both stale words dropped.
    mem_hold = 1'b1;
    repeat (6) tick();
    check_stream(0);
    check("hold_in_flight", 32'(mem_q.size()), 32'd2);
    check("hold_instr_valid", 32'(instr_valid), 32'd0);
    do_redirect(32'h0000_0100);
    check("redir_imem_addr", imem_addr, 32'h0000_0100);
    check("redir_no_credit", 32'(imem_req_valid), 32'd0);
    exp_pc   = 32'h0000_0100;
    mem_hold = 1'b0;
    repeat (12) tick();
    check_stream(3);

    // Back-to-back redirects while draining: the later target wins.
    mem_hold = 1'b1;
    repeat (6) tick();
    check_stream(0);
    do_redirect(32'h0000_0400);
    do_redirect(32'h0000_0500);
    exp_pc   = 32'h0000_0500;
    mem_hold = 1'b0;
    repeat (12) tick();
    check_stream(3);

    // Redirect coinciding with a pop and an arriving response.
    find_pop_with_resp();
    check_stream(0);
    do_redirect(32'h0000_0300);
    exp_pc = 32'h0000_0300;
    repeat (12) tick();
    check_stream(3);

    // Fetch address wraps from the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFF8;
    repeat (14) tick();
    check_stream(4);

`ifdef FETCH_MISALIGN_CHECK_EN
    do_redirect(32'h0000_0102);
    check("misalign_flag_set", 32'(fetch_misaligned), 32'd1);
    repeat (5) tick();
    check("halt_req_valid", 32'(imem_req_valid), 32'd0);
    check("halt_instr_valid", 32'(instr_valid), 32'd0);
    check("halt_in_flight", 32'(mem_q.size()), 32'd0);
    check("halt_no_pops", 32'(got.size()), 32'd0);
    do_redirect(32'h0000_0200);
    check("misalign_flag_clr", 32'(fetch_misaligned), 32'd0);
    exp_pc = 32'h0000_0200;
    repeat (12) tick();
    check_stream(3);
`else
    do_redirect(32'h0000_0202);
    exp_pc = 32'h0000_0200;
    repeat (12) tick();
    check_stream(3);
`endif

    // Reset mid-stream with a response in flight.
    find_pop_with_resp();
    check_stream(0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instruction", instruction, 32'd0);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_imem_addr", imem_addr, 32'd0);
    mem_q.delete();
    got.delete();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    exp_pc = 32'd0;
    repeat (12) tick();
    check_stream(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid  input  1  instruction word returned, in request order, no backpressure.
REQ-009 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-010 SHALL have port instr_valid  output  1  instruction available to decoder.
REQ-011 SHALL have port instr_ready  input  1  decoder consumes instruction.
REQ-012 SHALL have port instruction  output  32  head-of-buffer instruction.
REQ-013 SHALL have port pc  output  32  address of head-of-buffer instruction.
REQ-014 SHALL have port redirect_valid  input  1  branch/jump redirect pulse.
REQ-015 SHALL have port redirect_pc  input  32  redirect target.

Function
REQ-016 SHALL hold fetch_pc; request handshake (imem_req_valid && imem_req_ready) advances fetch_pc by 4, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-017 SHALL assert imem_req_valid only when outstanding + buffered < 2 and state is RUN or DRAIN; imem_addr = fetch_pc.
REQ-018 SHALL track outstanding requests (0..2): +1 on request handshake, -1 on imem_resp_valid, both same cycle -> unchanged.
REQ-019 SHALL push {request pc, imem_resp_data} into the 2-entry FIFO on a non-discarded response; credit rule guarantees no overflow.
REQ-020 SHALL present FIFO head on instruction/pc with instr_valid = not empty; pop on instr_valid && instr_ready; empty FIFO with arriving response SHALL NOT bypass (1-cycle response-to-valid latency).
REQ-021 SHALL support simultaneous push and pop on a full or partially full FIFO without loss.
REQ-022 On redirect_valid: flush FIFO, load fetch_pc = redirect_pc, set discard count = outstanding after this cycle's response/handshake, suppress request issue in that cycle, enter DRAIN if discard count > 0 else RUN.
REQ-023 In DRAIN each imem_resp_valid SHALL decrement discard count and be dropped; count reaching 0 -> RUN; new requests allowed in DRAIN within credit.
REQ-024 Redirect during DRAIN SHALL re-flush and recompute discard count per REQ-022.
REQ-025 Redirect has priority over pop and push in the same cycle; instr_valid SHALL be 0 the cycle after a redirect.
REQ-026 States: RUN, DRAIN, HALT (HALT only per REQ-031).

Reset
REQ-027 On reset_n low, asynchronously: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, discard = 0, state RUN.
REQ-028 Reset outputs: imem_req_valid 0, instr_valid 0, instruction 0, pc 0, imem_addr = RESET_PC.
REQ-029 Responses arriving after a reset mid-operation SHALL be ignored (memory is co-reset; no discard state survives).

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN SHALL select misaligned-redirect handling.
REQ-031 Defined: adds output fetch_misaligned (1 bit, reset 0); redirect with redirect_pc[1:0] != 0 sets it, flushes, enters HALT (no requests, drops any responses); next aligned redirect clears it and resumes per REQ-022.
REQ-032 Not defined: no fetch_misaligned port, no HALT state; redirect_pc[1:0] forced to 0.

Verification
REQ-033 Reset release, memory always ready, 1-cycle response, instr_ready=1 -> imem_addr 0,4,8,...; pc/instruction stream 0,4,8 in order, first instr_valid cycle 3.
REQ-034 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_valid 0, no lost or duplicated words after release.
REQ-035 Redirect to 32'h100 with 2 outstanding -> both responses dropped, next instruction pc 32'h100.
REQ-036 Redirect in same cycle as pop and response -> pop ignored, response counted as discarded, outstanding correct.
REQ-037 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> fetch_misaligned 1, no requests; redirect to 32'h200 -> cleared, fetch resumes at 32'h200.
REQ-038 reset_n asserted mid-stream with outstanding requests -> all outputs at reset values immediately, restart at RESET_PC.
